// File: rtl/card_pkg.sv
// Shared types for the card ROI streamer: FSM states, region mode,
// per-pixel stream tags and default frame geometry.
package card_pkg;

  localparam int FRAME_WIDTH  = 240;
  localparam int FRAME_HEIGHT = 320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } roi_state_t;

  typedef enum logic {
    ROI_FULL   = 1'b0,
    ROI_CORNER = 1'b1
  } roi_mode_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } roi_tag_t;

  localparam int TAG_W = $bits(roi_tag_t);

  // A shifted-down dimension never collapses below one pixel
  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/roi_skid_fifo.sv
// Small synchronous FIFO of {tag, pixel}; its count feeds the
// read-credit logic so outstanding BRAM reads always have a slot.
module roi_skid_fifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 19,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_wr;

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign w_pop   = i_pop && o_valid;
  assign w_wr    = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)
        r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)
        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_in) disable iff (rst_in)
    !(i_push && !w_pop && (r_count == CW'(DEPTH)))
  );

endmodule

// File: rtl/card_roi_streamer.sv
// Streams a card box (or its glyph corner) out of the frame BRAM.
// Optional ROI_SUBSAMPLE_EN adds sub_shift_in for 2^s decimation.
module card_roi_streamer
  import card_pkg::*;
#(
  parameter  int HEIGHT         = FRAME_HEIGHT,
  parameter  int WIDTH          = FRAME_WIDTH,
  parameter  int PIX_W          = 16,
  parameter  int READ_LAT       = 2,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int CORNER_X_SHIFT = 3,
  parameter  int CORNER_Y_SHIFT = 2,
  localparam int XW             = $clog2(WIDTH),
  localparam int YW             = $clog2(HEIGHT),
  localparam int AW             = $clog2(HEIGHT * WIDTH),
  localparam int CW             = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [XW-1:0]    left_edge,
  input  logic [XW-1:0]    right_edge,
  input  logic [YW-1:0]    top_edge,
  input  logic [YW-1:0]    bot_edge,
  input  logic             mode_in,
  input  logic             start_in,
`ifdef ROI_SUBSAMPLE_EN
  input  logic [1:0]       sub_shift_in,
`endif
  output logic [AW-1:0]    addr_out,
  input  logic [PIX_W-1:0] pixel_data_in,
  output logic [PIX_W-1:0] pix_data_out,
  output logic             pix_valid_out,
  input  logic             pix_ready_in,
  output logic             pix_sof_out,
  output logic             pix_eol_out,
  output logic             pix_eof_out,
  output logic [XW:0]      roi_w_out,
  output logic [YW:0]      roi_h_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out
);

  roi_state_t    r_state;
  roi_state_t    w_next;
  roi_mode_t     r_mode;
  logic [XW-1:0] r_left;
  logic [XW-1:0] r_right;
  logic [YW-1:0] r_top;
  logic [YW-1:0] r_bot;
  logic          r_err;
  logic [1:0]    w_shift;

  logic [XW:0]   r_roi_w;
  logic [YW:0]   r_roi_h;
  logic [XW:0]   r_col;
  logic [YW:0]   r_row;
  logic [XW-1:0] r_x;
  logic [AW-1:0] r_row_base;

  logic [READ_LAT-1:0] r_pv;
  roi_tag_t            r_pt [READ_LAT];
  logic [CW-1:0]       r_inflight;

  logic          w_invalid;
  logic [XW:0]   w_wfull;
  logic [YW:0]   w_hfull;
  logic [XW:0]   w_wsel;
  logic [YW:0]   w_hsel;
  logic [XW+1:0] w_wround;
  logic [YW+1:0] w_hround;
  logic [XW:0]   w_wemit;
  logic [YW:0]   w_hemit;
  logic [XW-1:0] w_xstep;
  logic [AW-1:0] w_ystep;

  logic          w_issue;
  logic          w_row_end;
  logic          w_last;
  roi_tag_t      w_tag;
  logic [CW-1:0] w_count;
  logic          w_fvalid;
  logic          w_fire;
  roi_tag_t      w_otag;
  logic [PIX_W-1:0] w_opix;

`ifdef ROI_SUBSAMPLE_EN
  logic [1:0] r_shift;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_shift <= 2'd0;
    else if (r_state == ST_IDLE && start_in)
      r_shift <= sub_shift_in;
  end

  assign w_shift = r_shift;
`else
  assign w_shift = 2'd0;
`endif

  // Box validation and region sizing, consumed in SETUP
  always_comb begin
    w_invalid = (r_left > r_right) || (r_top > r_bot) ||
                ({1'b0, r_right} >= (XW+1)'(WIDTH)) ||
                ({1'b0, r_bot} >= (YW+1)'(HEIGHT));
    w_wfull = {1'b0, r_right} - {1'b0, r_left} + (XW+1)'(1);
    w_hfull = {1'b0, r_bot} - {1'b0, r_top} + (YW+1)'(1);
    w_wsel  = w_wfull;
    w_hsel  = w_hfull;
    if (r_mode == ROI_CORNER) begin
      w_wsel = (XW+1)'(at_least_one(16'(w_wfull >> CORNER_X_SHIFT)));
      w_hsel = (YW+1)'(at_least_one(16'(w_hfull >> CORNER_Y_SHIFT)));
    end
    w_wround = {1'b0, w_wsel} + ((XW+2)'(1) << w_shift) - (XW+2)'(1);
    w_hround = {1'b0, w_hsel} + ((YW+2)'(1) << w_shift) - (YW+2)'(1);
    w_wemit  = (XW+1)'(w_wround >> w_shift);
    w_hemit  = (YW+1)'(w_hround >> w_shift);
    w_xstep  = XW'(1) << w_shift;
    w_ystep  = AW'(WIDTH) << w_shift;
  end

  assign w_issue = (r_state == ST_SCAN) &&
                   (({1'b0, w_count} + {1'b0, r_inflight}) <
                    (CW+1)'(FIFO_DEPTH));
  assign w_row_end = (r_col == r_roi_w - (XW+1)'(1));
  assign w_last    = w_row_end && (r_row == r_roi_h - (YW+1)'(1));
  assign w_tag.sof = (r_col == '0) && (r_row == '0);
  assign w_tag.eol = w_row_end;
  assign w_tag.eof = w_last;
  assign addr_out  = r_row_base + AW'(r_x);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode     <= ROI_FULL;
      r_left     <= '0;
      r_right    <= '0;
      r_top      <= '0;
      r_bot      <= '0;
      r_err      <= 1'b0;
      r_roi_w    <= '0;
      r_roi_h    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_x        <= '0;
      r_row_base <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_mode  <= roi_mode_t'(mode_in);
            r_left  <= left_edge;
            r_right <= right_edge;
            r_top   <= top_edge;
            r_bot   <= bot_edge;
            r_err   <= 1'b0;
          end
        end
        ST_SETUP: begin
          r_err      <= w_invalid;
          r_roi_w    <= w_invalid ? '0 : w_wemit;
          r_roi_h    <= w_invalid ? '0 : w_hemit;
          r_col      <= '0;
          r_row      <= '0;
          r_x        <= r_left;
          r_row_base <= AW'(r_top) * AW'(WIDTH);
        end
        ST_SCAN: begin
          if (w_issue) begin
            if (w_row_end) begin
              r_col      <= '0;
              r_row      <= r_row + (YW+1)'(1);
              r_x        <= r_left;
              r_row_base <= r_row_base + w_ystep;
            end else begin
              r_col <= r_col + (XW+1)'(1);
              r_x   <= r_x + w_xstep;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tags travel alongside each read until its BRAM data returns
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pv       <= '0;
      r_inflight <= '0;
      for (int i = 0; i < READ_LAT; i++) r_pt[i] <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pt[0] <= w_tag;
      for (int i = 1; i < READ_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(r_pv[READ_LAT-1]);
    end
  end

  roi_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (TAG_W + PIX_W)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (r_pv[READ_LAT-1]),
    .i_data  ({r_pt[READ_LAT-1], pixel_data_in}),
    .i_pop   (pix_ready_in),
    .o_data  ({w_otag, w_opix}),
    .o_valid (w_fvalid),
    .o_count (w_count)
  );

  assign w_fire        = w_fvalid && pix_ready_in;
  assign pix_valid_out = w_fvalid;
  assign pix_data_out  = w_fvalid ? w_opix : '0;
  assign pix_sof_out   = w_fvalid && w_otag.sof;
  assign pix_eol_out   = w_fvalid && w_otag.eol;
  assign pix_eof_out   = w_fvalid && w_otag.eof;
  assign roi_w_out     = r_roi_w;
  assign roi_h_out     = r_roi_h;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_in) w_next = ST_SETUP;
      ST_SETUP: w_next = w_invalid ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (w_issue && w_last) w_next = ST_DRAIN;
      ST_DRAIN: begin
        if ((w_fire && w_otag.eof) ||
            (w_count == '0 && r_inflight == '0))
          w_next = ST_DONE;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out = 1'b0;
    done_out = 1'b0;
    err_out  = 1'b0;
    unique case (r_state)
      ST_SETUP, ST_SCAN, ST_DRAIN: busy_out = 1'b1;
      ST_DONE: begin
        done_out = 1'b1;
        err_out  = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_card_roi_streamer.sv
// Directed bench for card_roi_streamer with a 2-cycle BRAM model
// whose data word is the low 16 bits of the address read.
module tb_card_roi_streamer;

  localparam int W = 240;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  left, right;
  logic [8:0]  top, bot;
  logic        mode, start;
  logic [16:0] addr;
  logic [15:0] pix_in, pix;
  logic        valid, ready, sof, eol, eof;
  logic [8:0]  roi_w;
  logic [9:0]  roi_h;
  logic        busy, done, err;
  logic [16:0] m1, m2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m1 <= addr;
    m2 <= m1;
  end
  assign pix_in = m2[15:0];

  card_roi_streamer dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .left_edge     (left),
    .right_edge    (right),
    .top_edge      (top),
    .bot_edge      (bot),
    .mode_in       (mode),
    .start_in      (start),
`ifdef ROI_SUBSAMPLE_EN
    .sub_shift_in  (2'd0),
`endif
    .addr_out      (addr),
    .pixel_data_in (pix_in),
    .pix_data_out  (pix),
    .pix_valid_out (valid),
    .pix_ready_in  (ready),
    .pix_sof_out   (sof),
    .pix_eol_out   (eol),
    .pix_eof_out   (eof),
    .roi_w_out     (roi_w),
    .roi_h_out     (roi_h),
    .busy_out      (busy),
    .done_out      (done),
    .err_out       (err)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, addr, valid, pix, sof, eol, eof,
            roi_w, roi_h, busy, done, err};
  endfunction

  task automatic run_box(input string nm, input int l, input int r,
                         input int t, input int b, input bit md,
                         input int ew, input int eh, input bit rnd,
                         input int abort_at, input bit exp_err);
    int n = 0, cyc = 0, eof_cyc = -1, done_cyc = -1, maxc = 0;
    int ea, exp_n;
    bit pv = 0, pr = 0, rd;
    logic [18:0] prev = '0, cur, expv;
    exp_n = exp_err ? 0 : ew * eh;
    @(negedge clk);
    left = 8'(l); right = 8'(r); top = 9'(t); bot = 9'(b);
    mode = md; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    left = 8'd200; right = 8'd3; top = 9'd300; bot = 9'd1; mode = ~md;
    chk($sformatf("%s_busy", nm), busy, 1);
    while (cyc < 3000) begin
      rd = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = rd;
      cur = {sof, eol, eof, pix};
      if (pv && !pr)
        chk($sformatf("%s_hold", nm), {valid, cur}, {1'b1, prev});
      if (valid && rd) begin
        ea = (t + n / ew) * W + l + n % ew;
        expv = {n == 0, (n % ew) == ew - 1, n == ew * eh - 1, 16'(ea)};
        chk($sformatf("%s_beat%0d", nm, n), cur, expv);
        if (n == ew * eh - 1) eof_cyc = cyc;
        n++;
      end
      if (int'(dut.u_fifo.r_count) > maxc) maxc = int'(dut.u_fifo.r_count);
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("%s_err", nm), err, exp_err);
        break;
      end
      if (abort_at >= 0 && n == abort_at) return;
      pv = valid; pr = rd; prev = cur;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("%s_gotdone", nm), done_cyc >= 0, 1);
    chk($sformatf("%s_nbeats", nm), n, exp_n);
    chk($sformatf("%s_fifomax", nm), maxc <= 4, 1);
    if (!exp_err) begin
      chk($sformatf("%s_donegap", nm), done_cyc - eof_cyc, 1);
      chk($sformatf("%s_roiw", nm), roi_w, ew);
      chk($sformatf("%s_roih", nm), roi_h, eh);
    end
    @(negedge clk);
    chk($sformatf("%s_idle", nm), {busy, done, err}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1; mode = 1'b0;
    left = '0; right = '0; top = '0; bot = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    run_box("full",   10,  13,  20,  21, 1'b0,  4,  2, 1'b0, -1, 1'b0);
    run_box("corner",  0,  79,   0, 159, 1'b1, 10, 40, 1'b0, -1, 1'b0);
    run_box("rnd",   100, 115, 200, 215, 1'b0, 16, 16, 1'b1, -1, 1'b0);
    run_box("errlr",  50,  40,   0,  10, 1'b0,  1,  1, 1'b0, -1, 1'b1);
    run_box("errr",   10, 240,   0,  10, 1'b0,  1,  1, 1'b0, -1, 1'b1);
    run_box("abort", 100, 115, 200, 215, 1'b0, 16, 16, 1'b0,  5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    run_box("after",  10,  13,  20,  21, 1'b0,  4,  2, 1'b0, -1, 1'b0);
    run_box("one",   239, 239, 319, 319, 1'b0,  1,  1, 1'b0, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_roi_streamer.md
Name: card_roi_streamer

Overview:
- Parametrised successor to the card isolator; given a card bounding box and a start pulse, reads the selected region from the camera frame BRAM and emits it as a ready/valid pixel stream.
- Sits between edge detection and suit/rank classification.
- Two modes: the full card box, or its top-left corner (suit/rank glyph).
- Tolerates BRAM read latency and downstream backpressure via a credit-limited skid FIFO.

Parameters:
HEIGHT, 320, frame height in pixels
WIDTH, 240, frame width in pixels
PIX_W, 16, pixel width (RGB565 default)
READ_LAT, 2, BRAM cycles from addr_out to pixel_data_in
FIFO_DEPTH, 4, skid FIFO entries; must be >= READ_LAT+1
CORNER_X_SHIFT, 3, corner width = box width >> this
CORNER_Y_SHIFT, 2, corner height = box height >> this

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
left_edge  in  $clog2(WIDTH)  box left column, inclusive
right_edge  in  $clog2(WIDTH)  box right column, inclusive
top_edge  in  $clog2(HEIGHT)  box top row, inclusive
bot_edge  in  $clog2(HEIGHT)  box bottom row, inclusive
mode_in  in  1  0 = full box, 1 = corner
start_in  in  1  single-cycle start pulse
addr_out  out  $clog2(HEIGHT*WIDTH)  frame BRAM read address
pixel_data_in  in  PIX_W  BRAM data, READ_LAT cycles after address
pix_data_out  out  PIX_W  stream pixel
pix_valid_out  out  1  stream valid
pix_ready_in  in  1  stream ready
pix_sof_out  out  1  first pixel of region, qualified by valid
pix_eol_out  out  1  last pixel of a row, qualified by valid
pix_eof_out  out  1  last pixel of region, qualified by valid
roi_w_out  out  $clog2(WIDTH)+1  latched region width
roi_h_out  out  $clog2(HEIGHT)+1  latched region height
busy_out  out  1  high from accepted start until done
done_out  out  1  one-cycle completion pulse
err_out  out  1  one-cycle pulse, box invalid

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- rst_in mid-scan aborts immediately; in-flight BRAM data is discarded. Reset wins over a simultaneous start.
- States are IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE:
  - start_in latches edges and mode, then goes to SETUP.
  - start_in outside IDLE is ignored.
- SETUP (1 cycle):
  - Box is invalid if left>right, top>bot, right>=WIDTH or bot>=HEIGHT. On invalid: err_out and done_out pulse together, then IDLE. No pixels are emitted.
  - Full mode: w = right-left+1, h = bot-top+1.
  - Corner mode: w = max(1, w_full>>CORNER_X_SHIFT), h = max(1, h_full>>CORNER_Y_SHIFT), anchored at (left, top).
  - roi_w_out/roi_h_out are latched here.
  - row_base = top*WIDTH, computed once; later rows add WIDTH, so there is no per-pixel multiply.
- SCAN:
  - Issue one read per cycle when credits > 0. credits = FIFO_DEPTH - occupancy - in_flight.
  - addr_out = row_base + x. x runs left..left+w-1, then wraps to left and row_base += WIDTH.
  - A READ_LAT-deep valid/tag shift register marks returning data and carries sof/eol/eof tags.
  - After the last address is issued, go to DRAIN.
- DRAIN: wait until in_flight = 0 and the FIFO is empty (eof beat accepted), then go to DONE.
- DONE: done_out pulses for 1 cycle, busy_out drops the same cycle, then IDLE.
- Stream rules:
  - A beat transfers on valid&ready.
  - Data and tags hold stable while valid & !ready.
  - No bubbles required when ready is held high; steady state is 1 pixel/clk.
  - FIFO never overflows; an assertion checks this.
- A 1x1 region sets sof, eol and eof on the same beat.
- Edge input changes after start have no effect.

Optional Feature:
- Macro ROI_SUBSAMPLE_EN.
- Defined: adds input sub_shift_in[1:0], latched at start. Region is read with step 2^sub_shift in x and y. Emitted w = ceil(w/2^s), h = ceil(h/2^s). roi_w_out/roi_h_out report the emitted size. Row advance adds WIDTH<<s.
- Undefined: port absent, step fixed at 1.

Decomposition:
- Package card_pkg holds:
  - roi_state_t enum
  - roi_mode_t enum (ROI_FULL, ROI_CORNER)
  - a pixel tag struct {sof, eol, eof}
  - localparams for default frame WIDTH/HEIGHT
- One sub-module, roi_skid_fifo: parametrised synchronous FIFO of {tag, pixel} with count output used for credits.

Test Plan:
- Full box left=10 right=13 top=20 bot=21, ready=1 -> 8 beats, addrs 4810..4813, 5050..5053; sof on beat 0, eol on beats 3 and 7, eof on beat 7; done 1 cycle after eof.
- Corner mode, box 0..79 x 0..159 -> roi 10x40, 400 beats, first addr 0, last addr 39*240+9 = 9369.
- Random ready (50%) on a 16x16 box -> all 256 pixels in order, none dropped or duplicated, FIFO count never exceeds 4, data stable while stalled.
- left=50 right=40 -> err_out and done_out same cycle, no valid beats, busy low next cycle; right=240 also errors.
- rst_in asserted mid-scan at beat 5 -> all outputs 0 that cycle; new start afterwards streams cleanly from sof.
- 1x1 box at (239,319) -> single beat, addr 76799, sof=eol=eof=1.
